cpu_run_controller: RTL
=======================

Name: cpu_run_controller

Overview:
- Sequencer for the 8-bit single-cycle processor.
- Owns the program memory: serves instruction for the current pc, and accepts program loads via a valid/ready handshake.
- Gates execution with a one-cycle cpu_tick enable, used as the processor clock enable.
- Provides run, single-step, halt, breakpoint and self-loop auto-halt.

Parameters:
- PROG_DEPTH, 256: program memory entries; addresses at or above PROG_DEPTH read 8'h00.
- TICK_DIV, 1: clk cycles per cpu_tick in RUN; minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  one-cycle start pulse.
- step  input  1  one-cycle single-step pulse.
- halt  input  1  one-cycle stop pulse.
- load_valid  input  1  loader offers a program byte.
- load_ready  output  1  controller accepts a program byte.
- load_addr  input  8  program byte address.
- load_data  input  8  program byte.
- load_last  input  1  marks the final byte of a load.
- pc  input  8  processor program counter.
- instruction  output  8  mem[pc], combinational read.
- cpu_tick  output  1  processor executes one instruction in this cycle.
- cpu_reset  output  1  active-high hold-reset to the processor.
- bp_enable  input  1  breakpoint armed.
- bp_addr  input  8  breakpoint pc.
- state  output  2  current state: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP.
- step_count  output  16  instructions executed since the last load.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, cpu_tick=0, cpu_reset=1, load_ready=0, step_count=0, divider counter=0.
  - Program memory is not cleared.
- cpu_reset=1 in IDLE only until the first RUN or STEP entry after a reset or a LOAD; then 0. It is 1 throughout LOAD.
- IDLE transitions, priority in this order:
  - load_valid → LOAD.
  - run → RUN.
  - step → STEP.
  - cpu_tick=0 while IDLE.
- LOAD:
  - load_ready=1.
  - A transfer occurs when load_valid & load_ready; it writes mem[load_addr]=load_data on that clk edge. Addresses ≥ PROG_DEPTH are dropped but still acknowledged.
  - A transfer with load_last=1 → IDLE next cycle.
  - step_count is cleared on LOAD entry.
  - run, step and halt are ignored in LOAD.
- RUN:
  - The divider counter resets to 0 on entry. cpu_tick pulses when the counter reaches TICK_DIV-1, and the counter wraps to 0. With TICK_DIV=1, cpu_tick is high every cycle.
  - halt in any RUN cycle → IDLE next cycle with no cpu_tick that cycle. halt wins over a coincident tick.
  - Breakpoint check: at a tick slot, if bp_enable and pc==bp_addr, the tick is suppressed → IDLE. The check is skipped for the first tick after RUN entry, so resuming from a breakpoint makes progress.
  - Self-loop auto-halt: if a tick issues while instruction==8'hFF (unconditional branch to self), → IDLE after that tick.
- STEP: exactly one cpu_tick in the entry cycle, ignoring breakpoints → IDLE. halt in that same cycle is ignored.
- step_count: increments on every cpu_tick and saturates at 16'hFFFF.
- Simultaneous events in IDLE: load_valid beats run, which beats step.
- Reset mid-operation: an asynchronous abort to IDLE. A load in progress is abandoned; bytes already written remain.

Optional Feature:
- Macro: CPU_RUN_CONTROLLER_BREAKPOINT_EN.
- Defined: breakpoint logic behaves as above.
- Undefined:
  - bp_enable and bp_addr are present but ignored.
  - No breakpoint comparator is synthesized.
  - RUN leaves only on halt, self-loop or reset.

Test Plan:
- Load then step: load bytes 0x00..0x02 = 8'h15, 8'h2A, 8'hFF with load_last on the third byte → three handshakes, state returns to IDLE, cpu_reset=1. With pc=0, instruction=8'h15. One step pulse → exactly one cpu_tick cycle, step_count=1, cpu_reset=0.
- Run to auto-halt: TICK_DIV=4, run pulse, bench advances pc on each tick → ticks at cycles 4, 8, 12. Tick at pc=2 (8'hFF) → IDLE; step_count=3.
- Breakpoint (macro defined): bp_enable=1, bp_addr=1, run → one tick at pc=0; the tick at pc=1 is suppressed and state=IDLE. A second run → tick at pc=1 issues.
- Halt vs tick: TICK_DIV=1 in RUN, halt asserted in a tick cycle → cpu_tick=0 that cycle, IDLE next cycle.
- Priority in IDLE: load_valid, run and step all high in one cycle → state=LOAD, load_ready=1, no cpu_tick.
- Reset mid-load: reset=0 after one of four bytes → immediate IDLE, load_ready=0, cpu_reset=1. Byte 0 is retained and bytes 1–3 are unchanged.

Source files
------------

// File: rtl/cpu_run_controller_if.sv
// rtl/cpu_run_controller_if.sv - program-load handshake between loader (master) and run controller (slave)
interface cpu_run_controller_if;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       load_last;

  modport master (
    output load_valid,
    output load_addr,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_addr,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - program memory, run/step/halt sequencer and cpu_tick gating for the 8-bit CPU
// Optional breakpoint comparator: CPU_RUN_CONTROLLER_BREAKPOINT_EN.
module cpu_run_controller #(
  parameter int PROG_DEPTH = 256,
  parameter int TICK_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 halt,
  cpu_run_controller_if.slave  load,
  input  logic [7:0]           pc,
  output logic [7:0]           instruction,
  output logic                 cpu_tick,
  output logic                 cpu_reset,
  input  logic                 bp_enable,
  input  logic [7:0]           bp_addr,
  output logic [1:0]           state,
  output logic [15:0]          step_count
);

  localparam int DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam logic [8:0]    DEPTH9   = 9'(PROG_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_t;

  state_t        st;
  logic [DW-1:0] div_cnt;
  logic          first_tick;
  logic          load_ready_q;
  logic          cpu_reset_q;
  logic [15:0]   step_cnt;

  logic [7:0]    mem [PROG_DEPTH];
  logic          rd_ok;
  logic          wr_ok;
  logic          xfer;
  logic          tick_slot;
  logic          bp_hit;
  logic          self_loop;
  logic          tick_ok;

  assign rd_ok       = ({1'b0, pc} < DEPTH9);
  assign wr_ok       = ({1'b0, load.load_addr} < DEPTH9);
  assign instruction = rd_ok ? mem[pc[AW-1:0]] : 8'h00;
  assign xfer        = (st == S_LOAD) && load.load_valid && load_ready_q;

  // Out-of-range bytes are still acknowledged; only the write is dropped.
  always_ff @(posedge clk) begin
    if (xfer && wr_ok) begin
      mem[load.load_addr[AW-1:0]] <= load.load_data;
    end
  end

  assign tick_slot = (div_cnt == DIV_LAST);
  assign self_loop = (instruction == 8'hFF);

`ifdef CPU_RUN_CONTROLLER_BREAKPOINT_EN
  // First tick after RUN entry skips the check so a resume from a breakpoint advances.
  assign bp_hit = (st == S_RUN) && tick_slot && bp_enable && (pc == bp_addr) && !first_tick;
`else
  assign bp_hit = 1'b0;
  logic unused_bp;
  assign unused_bp = ^{bp_enable, bp_addr, first_tick};
`endif

  always_comb begin
    tick_ok = 1'b0;
    case (st)
      S_RUN:   tick_ok = tick_slot && !halt && !bp_hit;
      S_STEP:  tick_ok = 1'b1;
      default: tick_ok = 1'b0;
    endcase
  end

  assign cpu_tick        = tick_ok;
  assign cpu_reset       = cpu_reset_q;
  assign load.load_ready = load_ready_q;
  assign state           = st;
  assign step_count      = step_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st           <= S_IDLE;
      div_cnt      <= '0;
      first_tick   <= 1'b0;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      step_cnt     <= 16'h0000;
    end else begin
      if (tick_ok && (step_cnt != 16'hFFFF)) begin
        step_cnt <= step_cnt + 16'h0001;
      end
      case (st)
        S_IDLE: begin
          if (load.load_valid) begin
            st           <= S_LOAD;
            load_ready_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            step_cnt     <= 16'h0000;
          end else if (run) begin
            st          <= S_RUN;
            div_cnt     <= '0;
            first_tick  <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else if (step) begin
            st          <= S_STEP;
            cpu_reset_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer && load.load_last) begin
            st           <= S_IDLE;
            load_ready_q <= 1'b0;
          end
        end
        S_RUN: begin
          div_cnt <= tick_slot ? '0 : div_cnt + 1'b1;
          if (tick_ok) begin
            first_tick <= 1'b0;
          end
          if (halt || bp_hit || (tick_ok && self_loop)) begin
            st <= S_IDLE;
          end
        end
        S_STEP: begin
          st <= S_IDLE;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule
